// File: rtl/fetch_pair_gen.sv
// rtl/fetch_pair_gen.sv - fetch PC generator and ICache pair pusher for the instruction buffer
// Issues aligned fetches in order, tracks them in a pending-PC FIFO, drops stale responses after a redirect.
module fetch_pair_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'hBFC0_0000,
  parameter int                MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              buffer_full_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [31:0]       rsp_inst1_i,
  input  logic [31:0]       rsp_inst2_i,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [ADDR_W-1:0] inst1_addr_o,
  output logic [ADDR_W-1:0] inst2_addr_o,
  output logic              inst1_valid_o,
  output logic              inst2_valid_o
);

  localparam int unsigned     CW       = $clog2(MAX_OUTST + 1);
  localparam int unsigned     PW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CW-1:0]   MAX_C    = CW'(MAX_OUTST);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [PW-1:0]   ONE_P    = PW'(1);
  localparam logic [PW-1:0]   LAST_P   = PW'(MAX_OUTST - 1);
  localparam logic [ADDR_W-4:0] ONE_LN = (ADDR_W-3)'(1);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   fifo_q [MAX_OUTST];
  logic                fifo_we;
  logic [31:0]         inst1_q, inst1_d, inst2_q, inst2_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
  logic                v1_q, v1_d, v2_q, v2_d;

  logic                kill, accept, rsp_fire, rsp_keep;
  logic [ADDR_W-1:0]   popped_pc;
  logic                unused_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + ONE_P;
  endfunction

  assign kill        = flush | redirect;
  assign accept      = req_o & req_ready_i;
  assign rsp_fire    = rsp_valid_i & (outst_q != '0);
  assign rsp_keep    = rsp_fire & (drop_q == '0) & ~kill;
  assign popped_pc   = fifo_q[rd_ptr_q];
  assign unused_lsbs = ^popped_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_BOOT;
    else      state_q <= state_d;
  end

  // Drain lasts exactly as long as stale responses are still owed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:           state_d = S_FETCH;
      S_FETCH, S_DRAIN: state_d = (drop_d != '0) ? S_DRAIN : S_FETCH;
      default:          state_d = S_BOOT;
    endcase
  end

  always_comb begin
    req_o      = 1'b0;
    req_o      = (state_q == S_FETCH) & ~buffer_full_i & (outst_q < MAX_C) & ~kill;
    req_addr_o = {pc_q[ADDR_W-1:3], 3'b000};
  end

  always_comb begin
    pc_d     = pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_we  = 1'b0;
    inst1_d  = inst1_q;
    inst2_d  = inst2_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    v1_d     = 1'b0;
    v2_d     = 1'b0;

    if (accept && !rsp_fire)      outst_d = outst_q + ONE_C;
    else if (!accept && rsp_fire) outst_d = outst_q - ONE_C;

    if (kill) begin
      // Everything still in flight becomes stale; the FIFO only ever holds live PCs.
      pc_d     = flush ? flush_pc : redirect_pc;
      drop_d   = outst_d;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) begin
        fifo_we  = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        pc_d     = {pc_q[ADDR_W-1:3] + ONE_LN, 3'b000};
      end
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - ONE_C;
      if (rsp_keep) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        inst1_d  = rsp_inst1_i;
        inst2_d  = rsp_inst2_i;
        addr1_d  = {popped_pc[ADDR_W-1:3], 3'b000};
        addr2_d  = {popped_pc[ADDR_W-1:3], 3'b100};
        v1_d     = ~popped_pc[2];
        v2_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
      inst1_q  <= '0;
      inst2_q  <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (fifo_we) fifo_q[wr_ptr_q] <= pc_q;
      inst1_q  <= inst1_d;
      inst2_q  <= inst2_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
    end
  end

  assign inst1_o       = inst1_q;
  assign inst2_o       = inst2_q;
  assign inst1_addr_o  = addr1_q;
  assign inst2_addr_o  = addr2_q;
  assign inst1_valid_o = v1_q;
  assign inst2_valid_o = v2_q;

endmodule

// File: tb/tb_fetch_pair_gen.sv
// tb/tb_fetch_pair_gen.sv - directed and randomized self-checking bench for fetch_pair_gen
// Reference model: in-order ICache queue of requests tagged stale on flush/redirect.
module tb_fetch_pair_gen;
  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam int          MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst, flush, redirect, buffer_full_i, req_ready_i, rsp_valid_i;
  logic [31:0] flush_pc, redirect_pc, rsp_inst1_i, rsp_inst2_i;
  logic        req_o, inst1_valid_o, inst2_valid_o;
  logic [31:0] req_addr_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;

  always #5 clk = ~clk;

  fetch_pair_gen #(.ADDR_W(32), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .buffer_full_i(buffer_full_i),
    .req_o(req_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_inst1_i(rsp_inst1_i), .rsp_inst2_i(rsp_inst2_i),
    .inst1_o(inst1_o), .inst2_o(inst2_o), .inst1_addr_o(inst1_addr_o),
    .inst2_addr_o(inst2_addr_o), .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    bit          stale;
    int          issue;
  } ent_t;

  ent_t        ic_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc, ei1, ei2, ea1, ea2;
  bit          boot, ev1, ev2;
  int          cyc, n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    ic_q.delete();
    acc_log.delete();
    exp_pc = RESET_PC;
    boot   = 1'b1;
    ev1    = 1'b0;
    ev2    = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, req_o, 0);
    chk({tag, "_v1"}, inst1_valid_o, 0);
    chk({tag, "_v2"}, inst2_valid_o, 0);
    chk({tag, "_i1"}, inst1_o, 0);
    chk({tag, "_i2"}, inst2_o, 0);
    chk({tag, "_a1"}, inst1_addr_o, 0);
    chk({tag, "_a2"}, inst2_addr_o, 0);
  endtask

  // One cycle: starts and ends just after a falling edge.
  task automatic step(input bit full, input bit ready, input bit fl, input logic [31:0] fpc,
                      input bit rd, input logic [31:0] rpc, input int rsp_pct);
    bit   exp_req, acc, rsp;
    int   n_stale;
    ent_t h, e;
    chk("push_v1", inst1_valid_o, ev1);
    chk("push_v2", inst2_valid_o, ev2);
    if (ev2) begin
      chk("push_i1", inst1_o, ei1);
      chk("push_i2", inst2_o, ei2);
      chk("push_a1", inst1_addr_o, ea1);
      chk("push_a2", inst2_addr_o, ea2);
    end
    buffer_full_i = full;
    req_ready_i   = ready;
    flush         = fl;
    flush_pc      = fpc;
    redirect      = rd;
    redirect_pc   = rpc;
    rsp = (ic_q.size() > 0) && (ic_q[0].issue < cyc) && (int'($urandom_range(99)) < rsp_pct);
    rsp_valid_i = rsp;
    if (rsp) begin
      rsp_inst1_i = ic_q[0].d1;
      rsp_inst2_i = ic_q[0].d2;
    end else begin
      rsp_inst1_i = $urandom;
      rsp_inst2_i = $urandom;
    end
    #1;
    n_stale = 0;
    foreach (ic_q[i]) if (ic_q[i].stale) n_stale++;
    exp_req = !boot && (n_stale == 0) && (ic_q.size() < MAX_OUTST) && !full && !fl && !rd;
    chk("req", req_o, exp_req);
    if (exp_req) chk("req_addr", req_addr_o, exp_pc & ~32'h7);
    acc = exp_req && ready;
    ev1 = 1'b0;
    ev2 = 1'b0;
    if (rsp) begin
      h = ic_q.pop_front();
      if (!h.stale && !fl && !rd) begin
        ev1 = !h.pc[2];
        ev2 = 1'b1;
        ei1 = h.d1;
        ei2 = h.d2;
        ea1 = h.pc & ~32'h7;
        ea2 = ea1 + 32'd4;
      end
    end
    if (fl || rd) begin
      foreach (ic_q[i]) ic_q[i].stale = 1'b1;
      exp_pc = fl ? fpc : rpc;
    end else if (acc) begin
      e.pc    = exp_pc;
      e.d1    = $urandom;
      e.d2    = $urandom;
      e.stale = 1'b0;
      e.issue = cyc;
      ic_q.push_back(e);
      acc_log.push_back(exp_pc & ~32'h7);
      exp_pc = (exp_pc & ~32'h7) + 32'd8;
    end
    boot = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b0; flush = 1'b0; redirect = 1'b0; flush_pc = '0; redirect_pc = '0;
    buffer_full_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    rsp_inst1_i = '0; rsp_inst2_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    repeat (8) step(0, 1, 0, 0, 0, 0, 100);
    chk("t1_req0", acc_at(0), 32'hBFC0_0000);
    chk("t1_req1", acc_at(1), 32'hBFC0_0008);
    chk("t1_req2", acc_at(2), 32'hBFC0_0010);

    repeat (5) step(1, 1, 0, 0, 0, 0, 100);
    repeat (4) step(0, 1, 0, 0, 0, 0, 100);

    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h8000_0184, 0, 0, 0);
    acc_log.delete();
    repeat (6) step(0, 1, 0, 0, 0, 0, 100);
    chk("t3_first_req", acc_at(0), 32'h8000_0180);

    step(0, 1, 1, 32'h8000_0380, 1, 32'h9FC0_0000, 100);
    acc_log.delete();
    repeat (6) step(0, 1, 0, 0, 0, 0, 100);
    chk("t4_first_req", acc_at(0), 32'h8000_0380);

    repeat (3) step(0, 0, 0, 0, 0, 0, 100);
    repeat (3) step(0, 1, 0, 0, 0, 0, 100);

    step(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 100);
    acc_log.delete();
    repeat (6) step(0, 1, 0, 0, 0, 0, 100);
    chk("wrap_top", acc_at(0), 32'hFFFF_FFF8);
    chk("wrap_zero", acc_at(1), 32'h0000_0000);

    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h1234_5678, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step(0, 1, 0, 0, 0, 0, 100);
    chk("t6_restart", acc_at(0), 32'hBFC0_0000);

    repeat (600) step($urandom_range(99) < 20, $urandom_range(99) < 70, $urandom_range(99) < 3,
                      $urandom, $urandom_range(99) < 4, $urandom, 60);
    repeat (8) step(1, 1, 0, 0, 0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
